// File: rtl/rgmii_mdio_speed_ctrl.sv
// Clause-22 MDIO master with a periodic PHY status poller that drives the RGMII
// speed select. Host register accesses take priority over polling.
module rgmii_mdio_speed_ctrl #(
  parameter int         CLK_DIV       = 4,
  parameter int         POLL_INTERVAL = 125000,
  parameter logic [4:0] STATUS_REG    = 5'h11,
  parameter int         SPEED_LSB     = 14,
  parameter int         LINK_BIT      = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [4:0]  phy_addr,
  input  logic        host_req,
  input  logic        host_wr,
  input  logic [4:0]  host_reg,
  input  logic [15:0] host_wdata,
  output logic        host_ack,
  output logic [15:0] host_rdata,
  output logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_t,
  output logic [1:0]  speed,
  output logic        link_up,
  output logic        status_valid,
  output logic        mdio_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, FRAME, GAP} state_t;

  localparam int DivW   = $clog2(2 * CLK_DIV);
  localparam int TimerW = (POLL_INTERVAL > 2) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [DivW-1:0]   DivRise  = DivW'(CLK_DIV);
  localparam logic [DivW-1:0]   DivLast  = DivW'(2 * CLK_DIV - 1);
  localparam logic [TimerW-1:0] TimerEnd = TimerW'(POLL_INTERVAL - 1);
  localparam logic [5:0]        BitTa1   = 6'd46;
  localparam logic [5:0]        BitTa2   = 6'd47;
  localparam logic [5:0]        BitData0 = 6'd48;
  localparam logic [5:0]        BitLast  = 6'd63;

  state_t             state_q, state_d;
  logic [DivW-1:0]    div_q, div_d;
  logic [5:0]         bit_q, bit_d;
  logic [63:0]        frame_q, frame_d;
  logic               isRead_q, isRead_d;
  logic               isHost_q, isHost_d;
  logic               taBad_q, taBad_d;
  logic [15:0]        rx_q, rx_d;
  logic               mdc_q, mdc_d;
  logic               mdioO_q, mdioO_d;
  logic               mdioT_q, mdioT_d;
  logic [1:0]         speed_q, speed_d;
  logic               link_q, link_d;
  logic               statusValid_q, statusValid_d;
  logic               hostAck_q, hostAck_d;
  logic [15:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               pend_q, pend_d;
  logic [TimerW-1:0]  timer_q, timer_d;

  logic               startHost, startPoll, startRead;
  logic [4:0]         startReg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      div_q         <= '0;
      bit_q         <= '0;
      frame_q       <= '1;
      isRead_q      <= 1'b0;
      isHost_q      <= 1'b0;
      taBad_q       <= 1'b0;
      rx_q          <= '0;
      mdc_q         <= 1'b0;
      mdioO_q       <= 1'b1;
      mdioT_q       <= 1'b1;
      speed_q       <= 2'b10;
      link_q        <= 1'b0;
      statusValid_q <= 1'b0;
      hostAck_q     <= 1'b0;
      rdata_q       <= '0;
      err_q         <= 1'b0;
      pend_q        <= 1'b1;
      timer_q       <= '0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      bit_q         <= bit_d;
      frame_q       <= frame_d;
      isRead_q      <= isRead_d;
      isHost_q      <= isHost_d;
      taBad_q       <= taBad_d;
      rx_q          <= rx_d;
      mdc_q         <= mdc_d;
      mdioO_q       <= mdioO_d;
      mdioT_q       <= mdioT_d;
      speed_q       <= speed_d;
      link_q        <= link_d;
      statusValid_q <= statusValid_d;
      hostAck_q     <= hostAck_d;
      rdata_q       <= rdata_d;
      err_q         <= err_d;
      pend_q        <= pend_d;
      timer_q       <= timer_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    div_d         = div_q;
    bit_d         = bit_q;
    frame_d       = frame_q;
    isRead_d      = isRead_q;
    isHost_d      = isHost_q;
    taBad_d       = taBad_q;
    rx_d          = rx_q;
    speed_d       = speed_q;
    link_d        = link_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    pend_d        = pend_q;
    timer_d       = timer_q;
    statusValid_d = 1'b0;
    hostAck_d     = 1'b0;

    startHost = host_req;
    startPoll = !host_req && pend_q && enable;
    startRead = host_req ? !host_wr : 1'b1;
    startReg  = host_req ? host_reg : STATUS_REG;

    if (!enable) begin
      timer_d = '0;
    end else if (!pend_q) begin
      if (timer_q == TimerEnd) begin
        pend_d  = 1'b1;
        timer_d = '0;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (startHost || startPoll) begin
          state_d  = FRAME;
          div_d    = '0;
          bit_d    = '0;
          isRead_d = startRead;
          isHost_d = startHost;
          taBad_d  = 1'b0;
          // Read frames carry all-ones past REGAD; those bits go out released.
          frame_d  = {32'hFFFF_FFFF, 2'b01, (startRead ? 2'b10 : 2'b01), phy_addr,
                      startReg, (startRead ? 18'h3FFFF : {2'b10, host_wdata})};
        end
      end
      FRAME: begin
        div_d = div_q + 1'b1;
        if (div_q == DivRise && isRead_q) begin
          if (bit_q == BitTa2) begin
            taBad_d = mdio_i;
            err_d   = mdio_i;
          end else if (bit_q >= BitData0) begin
            rx_d = {rx_q[14:0], mdio_i};
          end
        end
        if (div_q == DivLast) begin
          div_d = '0;
          if (bit_q == BitLast) state_d = GAP;
          else                  bit_d   = bit_q + 1'b1;
        end
      end
      GAP: begin
        div_d = div_q + 1'b1;
        if (div_q == DivLast) begin
          state_d = IDLE;
          div_d   = '0;
          if (isHost_q) begin
            hostAck_d = 1'b1;
            if (isRead_q && !taBad_q) rdata_d = rx_q;
          end else begin
            statusValid_d = 1'b1;
            pend_d        = 1'b0;
            timer_d       = '0;
            if (taBad_q) begin
              link_d = 1'b0;
            end else begin
              link_d = rx_q[LINK_BIT];
              if (rx_q[LINK_BIT] && rx_q[SPEED_LSB +: 2] != 2'b11) speed_d = rx_q[SPEED_LSB +: 2];
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    mdc_d   = (state_d == FRAME) && (div_d >= DivRise);
    mdioO_d = mdioO_q;
    mdioT_d = mdioT_q;
    if (state_d != FRAME) begin
      mdioO_d = 1'b1;
      mdioT_d = 1'b1;
    end else if (div_d == '0) begin
      mdioO_d = frame_d[6'd63 - bit_d];
      mdioT_d = isRead_d && (bit_d >= BitTa1);
    end
  end

  assign mdc          = mdc_q;
  assign mdio_o       = mdioO_q;
  assign mdio_t       = mdioT_q;
  assign speed        = speed_q;
  assign link_up      = link_q;
  assign status_valid = statusValid_q;
  assign host_ack     = hostAck_q;
  assign host_rdata   = rdata_q;
  assign mdio_err     = err_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_rgmii_mdio_speed_ctrl.sv
// Scoreboard bench for rgmii_mdio_speed_ctrl: a behavioural PHY answers read frames,
// expected frames and status are queued when stimulus is issued and checked on ack/status_valid.
`timescale 1ns/1ps
module tb_rgmii_mdio_speed_ctrl;

  localparam int         ClkDiv       = 4;
  localparam int         PollInterval = 200;
  localparam logic [4:0] StatusReg    = 5'h11;
  localparam int         FrameCycles  = 65 * 2 * ClkDiv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [4:0]  phy_addr = 5'd1;
  logic        host_req = 1'b0;
  logic        host_wr = 1'b0;
  logic [4:0]  host_reg = 5'd0;
  logic [15:0] host_wdata = 16'h0;
  logic        host_ack;
  logic [15:0] host_rdata;
  logic        mdc;
  logic        mdio_i = 1'b1;
  logic        mdio_o;
  logic        mdio_t;
  logic [1:0]  speed;
  logic        link_up;
  logic        status_valid;
  logic        mdio_err;
  logic        busy;

  rgmii_mdio_speed_ctrl #(
    .CLK_DIV(ClkDiv), .POLL_INTERVAL(PollInterval), .STATUS_REG(StatusReg),
    .SPEED_LSB(14), .LINK_BIT(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .phy_addr(phy_addr),
    .host_req(host_req), .host_wr(host_wr), .host_reg(host_reg), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata), .mdc(mdc), .mdio_i(mdio_i),
    .mdio_o(mdio_o), .mdio_t(mdio_t), .speed(speed), .link_up(link_up),
    .status_valid(status_valid), .mdio_err(mdio_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        isHost;
    logic [63:0] bits;
    logic [63:0] tBits;
    logic [63:0] care;
    logic [15:0] rdata;
    logic [1:0]  speed;
    logic        link;
    logic        err;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   evCount = 0;
  int   evExpected = 0;
  int   svCount = 0;
  int   cyc = 0;
  int   startCyc = 0;
  logic busyPrev = 1'b0;

  logic [1:0]  mSpeed = 2'b10;
  logic        mLink = 1'b0;
  logic        mErr = 1'b0;
  logic [15:0] mRdata = 16'h0;

  logic [63:0] capO = '0;
  logic [63:0] capT = '0;
  int          capN = 0;
  logic [15:0] phyResp = 16'h0;
  logic        phyPresent = 1'b1;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // PHY model: records what the master drives and answers read frames after TA.
  always @(posedge busy) capN = 0;
  always @(posedge mdc) begin
    capO = {capO[62:0], mdio_o};
    capT = {capT[62:0], mdio_t};
    capN = capN + 1;
  end
  always @(negedge mdc) begin
    logic [3:0] idx;
    idx = 4'(63 - capN);
    if (phyPresent && capT[0] && capN >= 47 && capN <= 63)
      mdio_i = (capN == 47) ? 1'b0 : phyResp[idx];
    else
      mdio_i = 1'b1;
  end

  function automatic exp_t frameExp(input logic isHost, input logic rd, input logic [4:0] pa,
                                    input logic [4:0] ra, input logic [15:0] wd);
    exp_t e;
    e = '0;
    e.isHost = isHost;
    if (rd) begin
      e.bits  = {32'hFFFF_FFFF, 2'b01, 2'b10, pa, ra, 18'h0};
      e.tBits = 64'h3FFFF;
      e.care  = {{46{1'b1}}, 18'h0};
    end else begin
      e.bits  = {32'hFFFF_FFFF, 2'b01, 2'b01, pa, ra, 2'b10, wd};
      e.tBits = 64'h0;
      e.care  = '1;
    end
    return e;
  endfunction

  task automatic pushPoll(input logic [15:0] resp, input logic present);
    exp_t e;
    e = frameExp(1'b0, 1'b1, phy_addr, StatusReg, 16'h0);
    if (!present) begin
      mErr  = 1'b1;
      mLink = 1'b0;
    end else begin
      mErr  = 1'b0;
      mLink = resp[10];
      if (resp[10] && resp[15:14] != 2'b11) mSpeed = resp[15:14];
    end
    e.speed = mSpeed;
    e.link  = mLink;
    e.err   = mErr;
    e.rdata = mRdata;
    expQ.push_back(e);
    evExpected++;
  endtask

  task automatic applyStimulus(input logic wr, input logic [4:0] ra, input logic [15:0] wd);
    exp_t e;
    e = frameExp(1'b1, !wr, phy_addr, ra, wd);
    if (!wr) begin
      if (phyPresent) begin
        mErr   = 1'b0;
        mRdata = phyResp;
      end else begin
        mErr = 1'b1;
      end
    end
    e.speed = mSpeed;
    e.link  = mLink;
    e.err   = mErr;
    e.rdata = mRdata;
    expQ.push_back(e);
    evExpected++;
    host_wr    = wr;
    host_reg   = ra;
    host_wdata = wd;
    host_req   = 1'b1;
  endtask

  task automatic hostWait(input int dropAfter, input int paChangeAt, input logic [4:0] newPa);
    logic acked = 1'b0;
    for (int n = 1; n <= 2000 && !acked; n++) begin
      @(negedge clk);
      if (host_ack) acked = 1'b1;
      else begin
        if (n == dropAfter) host_req = 1'b0;
        if (n == paChangeAt) phy_addr = newPa;
      end
    end
    host_req = 1'b0;
    checkOutput("hostAckSeen", 64'(acked), 64'd1);
    @(negedge clk);
    checkOutput("hostAckPulse", 64'(host_ack), 64'd0);
  endtask

  task automatic waitEvents(input int target, input int budget);
    int n = 0;
    while (evCount < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("eventsSeen", 64'(evCount), 64'(target));
  endtask

  task automatic scoreEvent();
    exp_t e;
    evCount++;
    if (status_valid) svCount++;
    checkOutput("sbNotEmpty", 64'(expQ.size() > 0), 64'd1);
    if (expQ.size() == 0) return;
    e = expQ.pop_front();
    checkOutput("eventKind", {62'd0, host_ack, status_valid}, e.isHost ? 64'd2 : 64'd1);
    checkOutput("frameLen", 64'(cyc - startCyc), 64'(FrameCycles));
    checkOutput("bitCount", 64'(capN), 64'd64);
    checkOutput("mdioBits", capO & e.care, e.bits & e.care);
    checkOutput("mdioTri", capT, e.tBits);
    checkOutput("mdioErr", 64'(mdio_err), 64'(e.err));
    if (e.isHost) begin
      checkOutput("hostRdata", 64'(host_rdata), 64'(e.rdata));
    end else begin
      checkOutput("speed", 64'(speed), 64'(e.speed));
      checkOutput("linkUp", 64'(link_up), 64'(e.link));
    end
  endtask

  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (busy && !busyPrev) startCyc = cyc;
    busyPrev = busy;
    if (status_valid || host_ack) scoreEvent();
  end

  initial begin
    #500us;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic reached;
    repeat (3) @(negedge clk);
    checkOutput("rstMdc", 64'(mdc), 64'd0);
    checkOutput("rstMdioO", 64'(mdio_o), 64'd1);
    checkOutput("rstMdioT", 64'(mdio_t), 64'd1);
    checkOutput("rstSpeed", 64'(speed), 64'd2);
    checkOutput("rstLink", 64'(link_up), 64'd0);
    checkOutput("rstStatusValid", 64'(status_valid), 64'd0);
    checkOutput("rstHostAck", 64'(host_ack), 64'd0);
    checkOutput("rstRdata", 64'(host_rdata), 64'd0);
    checkOutput("rstErr", 64'(mdio_err), 64'd0);
    checkOutput("rstBusy", 64'(busy), 64'd0);
    rst_n = 1'b1;

    // Polls: 1G up, 100M up, no PHY, link down.
    phyResp = 16'h8400;
    pushPoll(16'h8400, 1'b1);
    enable = 1'b1;
    waitEvents(evExpected, 2000);
    phyResp = 16'h4400;
    pushPoll(16'h4400, 1'b1);
    waitEvents(evExpected, 2000);
    phyPresent = 1'b0;
    phyResp = 16'h8400;
    pushPoll(16'h8400, 1'b0);
    waitEvents(evExpected, 2000);
    phyPresent = 1'b1;
    phyResp = 16'h0000;
    pushPoll(16'h0000, 1'b1);
    waitEvents(evExpected, 2000);
    enable = 1'b0;

    // Host accesses: write, read with early drop and mid-frame phy_addr change, read with no PHY.
    @(negedge clk);
    phy_addr = 5'd3;
    applyStimulus(1'b1, 5'd0, 16'h1140);
    hostWait(0, 0, 5'd0);
    phyResp = 16'h1234;
    applyStimulus(1'b0, 5'd2, 16'h0);
    hostWait(100, 150, 5'd7);
    phy_addr = 5'd3;
    phyPresent = 1'b0;
    applyStimulus(1'b0, 5'd2, 16'h0);
    hostWait(0, 0, 5'd0);
    phyPresent = 1'b1;
    waitEvents(evExpected, 100);

    // Reset mid-poll, then host and pending poll collide in the first idle cycle.
    phy_addr = 5'd1;
    phyResp = 16'h8400;
    enable = 1'b1;
    reached = 1'b0;
    for (int n = 0; n < 1500 && !reached; n++) begin
      @(negedge clk);
      if (busy && capN >= 40) reached = 1'b1;
    end
    checkOutput("reachBit40", 64'(reached), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midRstMdc", 64'(mdc), 64'd0);
    checkOutput("midRstMdioT", 64'(mdio_t), 64'd1);
    checkOutput("midRstSpeed", 64'(speed), 64'd2);
    checkOutput("midRstBusy", 64'(busy), 64'd0);
    checkOutput("midRstErr", 64'(mdio_err), 64'd0);
    checkOutput("midRstRdata", 64'(host_rdata), 64'd0);
    mSpeed = 2'b10;
    mLink  = 1'b0;
    mErr   = 1'b0;
    mRdata = 16'h0;
    applyStimulus(1'b1, 5'd4, 16'hABCD);
    pushPoll(16'h8400, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    hostWait(0, 0, 5'd0);
    waitEvents(evExpected, 2000);
    enable = 1'b0;
    repeat (20) @(negedge clk);

    checkOutput("pollCount", 64'(svCount), 64'd5);
    checkOutput("sbLeft", 64'(expQ.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgmii_mdio_speed_ctrl.md
Name: rgmii_mdio_speed_ctrl

Overview:
- Clause-22 MDIO master and link-status scheduler that sets the `speed` input of the RGMII PHY interface.
- Periodically polls a PHY status register and decodes link and speed from it.
- Shares the MDIO bus between this internal poller and a host register-access port; the host has priority.
- Runs in the `gmii_gtx_clk` domain next to the RGMII PHY interface.

Parameters:
- CLK_DIV, 4: clk cycles per MDC half-period (MDC = clk/(2*CLK_DIV)); must be >= 2.
- POLL_INTERVAL, 125000: idle clk cycles from the end of one poll frame to the next poll request.
- STATUS_REG, 5'h11: PHY register address read by the poller.
- SPEED_LSB, 14: bit position of the 2-bit speed field in the status word (10=1G, 01=100M, 00=10M, 11=reserved).
- LINK_BIT, 10: bit position of the link-up flag in the status word.

Ports:
- clk in 1: system clock (gmii_gtx_clk domain).
- rst_n in 1: asynchronous active-low reset.
- enable in 1: allows the periodic poll.
- phy_addr in 5: MDIO PHY address used for all frames.
- host_req in 1: host access request; level, held until host_ack.
- host_wr in 1: 1=write, 0=read; sampled with host_req.
- host_reg in 5: host register address.
- host_wdata in 16: host write data.
- host_ack out 1: one-cycle pulse when the host frame completes.
- host_rdata out 16: read data; valid with host_ack, held until the next host read.
- mdc out 1: MDIO clock.
- mdio_i in 1: MDIO input from the pad.
- mdio_o out 1: MDIO output data.
- mdio_t out 1: tristate control; 1 = release (hi-Z).
- speed out 2: to the RGMII PHY interface `speed` input.
- link_up out 1: decoded link status.
- status_valid out 1: one-cycle pulse after every poll frame.
- mdio_err out 1: the last frame saw no PHY turnaround; sticky until the next successful frame.
- busy out 1: a frame is in progress.

Behaviour:
- Reset values (asynchronous, immediate, including mid-frame): mdc=0, mdio_o=1, mdio_t=1, speed=2'b10, link_up=0, status_valid=0, host_ack=0, host_rdata=0, mdio_err=0, busy=0. Poll timer cleared and poll pending set, so the first poll starts once enable=1.
- States: IDLE, FRAME, GAP.
- IDLE:
  - If host_req=1, latch host_wr/host_reg/host_wdata and enter FRAME.
  - Else if poll pending and enable=1, enter FRAME as a read of STATUS_REG.
  - Host beats poll when both are present in the same cycle; the poll stays pending.
- Bit timing, each bit is 2*CLK_DIV cycles:
  - MDC low for the first CLK_DIV cycles, high for the second CLK_DIV cycles.
  - mdio_o/mdio_t update on the cycle MDC falls (bit start).
  - mdio_i is sampled in the cycle MDC rises.
  - MDC is held low outside FRAME.
- Frame, 64 bits, bit counter 0..63:
  - Bits 0-31: preamble, all 1s.
  - ST=01.
  - OP: 10 for read, 01 for write.
  - PHYAD = phy_addr, latched at frame start; then REGAD, both MSB first.
  - TA: write drives 10. Read releases mdio_t=1 for both TA bits and the 16 data bits.
  - Data: 16 bits, MSB first.
- Read turnaround check: the second TA bit is sampled.
  - If it is 1 (no PHY response), set mdio_err=1. Data is still shifted but discarded: host_rdata unchanged, speed unchanged, link_up forced to 0.
  - Otherwise clear mdio_err.
- After bit 63, enter GAP: one bit period with mdio_t=1 and mdc=0.
- At GAP exit, return to IDLE.
  - Host frame: pulse host_ack (with host_rdata for reads).
  - Poll frame: pulse status_valid, clear poll pending, restart the timer.
- Poll decode (TA valid only):
  - link_up = status[LINK_BIT].
  - If link_up=1 and the speed field != 11, speed = field.
  - Otherwise speed holds its previous value.
- Poll timer:
  - Counts only in IDLE/FRAME/GAP when enable=1 and no poll is pending.
  - At POLL_INTERVAL-1, set poll pending.
  - enable=0 clears the timer; an in-progress frame always completes.
- host_req dropped before ack is ignored; the frame completes and host_ack still pulses.
- phy_addr changes mid-frame have no effect until the next frame.
- busy=1 from FRAME entry through the end of GAP.

Test Plan:
- Poll, link up at 1G: CLK_DIV=4, enable=1, PHY model returns 16'h8400 at reg 0x11 -> one read frame with exact bit pattern, status_valid after 65*8=520 cycles, speed=2'b10, link_up=1.
- Speed change to 100M then down: responses 16'h4400 then 16'h0000 -> speed=01 and link_up=1; then link_up=0 with speed still 01.
- No PHY (mdio_i held 1) -> mdio_err=1, link_up=0, speed unchanged; PHY restored -> mdio_err clears on the next poll.
- Host write, phy_addr=3, reg 0, data 16'h1140 -> frame 32x'1',01,01,00011,00000,10,0001000101000000; host_ack once; mdio_t=0 for all 64 bits.
- host_req and poll pending in the same IDLE cycle -> host frame first, then poll frame after GAP; the status_valid pulse count is unaffected.
- rst_n low at bit 40 -> mdio_t=1, mdc=0, speed=2'b10 in the same cycle; after release, a fresh full frame starts from preamble.
